// File: rtl/tagged_target_cache_pkg.sv
// Package tc_pkg: shared configuration, types and hash helpers for the
// tagged indirect-branch target cache.
//
// Contents:
//   SETS, WAYS, BHR_W, TAG_W, ADDR_W  geometry of the cache (single point
//                                     of configuration for the whole slice)
//   IDX_W, PLRU_W, WAY_W              derived widths
//   fsm_t                             INIT / RUN sequencing states
//   entry_t                           one way of one set
//   tc_index(), tc_tag()              PC/history hash shared by lookup and update
//
// Optional build macro: TARGET_CONF_EN adds a 2-bit confidence counter to
// every entry.  Geometry must satisfy ADDR_W >= 2*IDX_W+TAG_W+2.
package tc_pkg;

   localparam int SETS   = 256;
   localparam int WAYS   = 2;
   localparam int BHR_W  = 10;
   localparam int TAG_W  = 8;
   localparam int ADDR_W = 32;

   localparam int IDX_W  = $clog2(SETS);
   localparam int PLRU_W = WAYS - 1;
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } fsm_t;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [ADDR_W-1:0] target;
`ifdef TARGET_CONF_EN
      logic [1:0]        conf;
`endif
   } entry_t;

   // Two PC slices folded together with the low history bits.
   function automatic logic [IDX_W-1:0] tc_index(input logic [ADDR_W-1:0] pc,
                                                 input logic [BHR_W-1:0]  bhr);
      return pc[IDX_W+1:2] ^ pc[2*IDX_W+1:IDX_W+2] ^ IDX_W'(bhr);
   endfunction

   // PC bits above the index slices, folded with the history bits the index
   // did not consume.
   function automatic logic [TAG_W-1:0] tc_tag(input logic [ADDR_W-1:0] pc,
                                               input logic [BHR_W-1:0]  bhr);
      return pc[2*IDX_W+TAG_W+1:2*IDX_W+2] ^ TAG_W'(bhr >> IDX_W);
   endfunction

endpackage

// File: rtl/tagged_target_cache_if.sv
// Lookup/update bus of the tagged target cache.
//   master: fetch/resolve side (drives lookup_* and update_*)
//   slave : the cache (drives ready and pred_*)
interface tagged_target_cache_if;
   import tc_pkg::*;

   logic              ready;
   logic              lookup_en;
   logic [ADDR_W-1:0] lookup_pc;
   logic [BHR_W-1:0]  lookup_bhr;
   logic              pred_valid;
   logic              pred_hit;
   logic [ADDR_W-1:0] pred_target;
   logic              update_en;
   logic [ADDR_W-1:0] update_pc;
   logic [BHR_W-1:0]  update_bhr;
   logic [ADDR_W-1:0] update_target;

   modport master (
      input  ready, pred_valid, pred_hit, pred_target,
      output lookup_en, lookup_pc, lookup_bhr,
      output update_en, update_pc, update_bhr, update_target
   );

   modport slave (
      output ready, pred_valid, pred_hit, pred_target,
      input  lookup_en, lookup_pc, lookup_bhr,
      input  update_en, update_pc, update_bhr, update_target
   );

endinterface

// File: rtl/tagged_target_cache_plru.sv
// tc_plru: tree pseudo-LRU state for every set of the cache.
//
// Ports:
//   clk                  clock
//   clr_en, clr_idx      zero the tree of one set (init sweep)
//   touch_a_*            lookup-hit touch (set, way)
//   touch_b_*            update touch; overrides touch_a on the same set
//   vic_idx -> vic_way   victim way of the selected set
//
// Tree encoding: node n has children 2n+1 (left) and 2n+2 (right); a node bit
// of 0 points the victim left, 1 points it right.  Touching a way points every
// node on its path away from it.
module tc_plru
   import tc_pkg::*;
(
   input  logic             clk,
   input  logic             clr_en,
   input  logic [IDX_W-1:0] clr_idx,
   input  logic             touch_a_en,
   input  logic [IDX_W-1:0] touch_a_idx,
   input  logic [WAY_W-1:0] touch_a_way,
   input  logic             touch_b_en,
   input  logic [IDX_W-1:0] touch_b_idx,
   input  logic [WAY_W-1:0] touch_b_way,
   input  logic [IDX_W-1:0] vic_idx,
   output logic [WAY_W-1:0] vic_way
);

   localparam int LVL = $clog2(WAYS);
   localparam int NW  = (PLRU_W > 1) ? $clog2(PLRU_W) : 1;

   logic [PLRU_W-1:0] bits_q [SETS];
   logic [PLRU_W-1:0] a_bits_d;
   logic [PLRU_W-1:0] b_bits_d;
   logic              a_wr;

   function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] cur,
                                                    input logic [WAY_W-1:0]  way);
      logic [PLRU_W-1:0] nb;
      logic              d;
      int                n;
      nb = cur;
      n  = 0;
      for (int l = 0; l < LVL; l++) begin
         d         = way[LVL-1-l];
         nb[NW'(n)] = ~d;
         n         = 2*n + 1 + int'(d);
      end
      return nb;
   endfunction

   function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] cur);
      logic [WAY_W-1:0] v;
      logic             d;
      int               n;
      v = '0;
      n = 0;
      for (int l = 0; l < LVL; l++) begin
         d          = cur[NW'(n)];
         v[LVL-1-l] = d;
         n          = 2*n + 1 + int'(d);
      end
      return v;
   endfunction

   always_comb begin
      a_bits_d = plru_touch(bits_q[touch_a_idx], touch_a_way);
      b_bits_d = plru_touch(bits_q[touch_b_idx], touch_b_way);
      a_wr     = touch_a_en && !(touch_b_en && (touch_a_idx == touch_b_idx));
      vic_way  = plru_victim(bits_q[vic_idx]);
   end

   always_ff @(posedge clk) begin
      if (clr_en) begin
         bits_q[clr_idx] <= '0;
      end else begin
         if (a_wr)       bits_q[touch_a_idx] <= a_bits_d;
         if (touch_b_en) bits_q[touch_b_idx] <= b_bits_d;
      end
   end

endmodule

// File: rtl/tagged_target_cache.sv
// tagged_target_cache: set-associative tagged indirect-branch target predictor.
//
// Ports:
//   clk     clock
//   resetn  synchronous active-low reset; restarts the init sweep
//   bus     tagged_target_cache_if.slave
//             ready                  high once every set has been cleared
//             lookup_en/pc/bhr    -> pred_valid/hit/target one cycle later
//             update_en/pc/bhr/target from branch resolve
//
// Lookups read the arrays before the same edge's update writes them, so a
// same-cycle update is never bypassed to the lookup.
//
// Optional build macro: TARGET_CONF_EN (2-bit per-entry confidence gating
// target replacement).  Ports are the same in both builds.
//
// State | meaning
// INIT  | clearing valid/PLRU of set cnt_q each cycle; lookups/updates ignored
// RUN   | normal lookup and update operation
module tagged_target_cache
   import tc_pkg::*;
(
   input  logic                   clk,
   input  logic                   resetn,
   tagged_target_cache_if.slave   bus
);

   fsm_t              state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic              clr_en;
   logic              run_en;

   entry_t            mem_q [SETS][WAYS];

   logic [IDX_W-1:0]  l_idx;
   logic [TAG_W-1:0]  l_tag;
   logic              l_hit;
   logic [WAY_W-1:0]  l_way;
   logic [ADDR_W-1:0] l_target;
   logic              lk_act;

   logic [IDX_W-1:0]  u_idx;
   logic [TAG_W-1:0]  u_tag;
   logic              u_hit;
   logic [WAY_W-1:0]  u_hit_way;
   logic              u_inv;
   logic [WAY_W-1:0]  u_inv_way;
   logic              u_act;
   logic [WAY_W-1:0]  vic_way;
   logic [WAY_W-1:0]  wr_way;
   entry_t            wr_entry;
`ifdef TARGET_CONF_EN
   entry_t            u_old;
`endif

   logic              pred_valid_q, pred_valid_d;
   logic              pred_hit_q, pred_hit_d;
   logic [ADDR_W-1:0] pred_target_q, pred_target_d;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(SETS-1)) state_d = RUN;
         end
         RUN:     state_d = RUN;
         default: state_d = INIT;
      endcase
   end

   // FSM: outputs.  resetn gates run_en so nothing is written in a reset cycle.
   always_comb begin
      clr_en = (state_q == INIT);
      run_en = (state_q == RUN) && resetn;
   end

   assign bus.ready = (state_q == RUN);

   // Lookup
   always_comb begin
      l_idx    = tc_index(bus.lookup_pc, bus.lookup_bhr);
      l_tag    = tc_tag(bus.lookup_pc, bus.lookup_bhr);
      l_hit    = 1'b0;
      l_way    = '0;
      l_target = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (mem_q[l_idx][w].valid && (mem_q[l_idx][w].tag == l_tag)) begin
            l_hit    = 1'b1;
            l_way    = WAY_W'(w);
            l_target = mem_q[l_idx][w].target;
         end
      end
      lk_act        = bus.lookup_en && run_en;
      pred_valid_d  = lk_act;
      pred_hit_d    = lk_act && l_hit;
      pred_target_d = (lk_act && l_hit) ? l_target : '0;
   end

   // Update: way selection and the entry to write
   always_comb begin
      u_idx     = tc_index(bus.update_pc, bus.update_bhr);
      u_tag     = tc_tag(bus.update_pc, bus.update_bhr);
      u_act     = bus.update_en && run_en;
      u_hit     = 1'b0;
      u_hit_way = '0;
      u_inv     = 1'b0;
      u_inv_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (mem_q[u_idx][w].valid && (mem_q[u_idx][w].tag == u_tag)) begin
            u_hit     = 1'b1;
            u_hit_way = WAY_W'(w);
         end
         if (!mem_q[u_idx][w].valid && !u_inv) begin
            u_inv     = 1'b1;
            u_inv_way = WAY_W'(w);
         end
      end
      wr_way = u_hit ? u_hit_way : (u_inv ? u_inv_way : vic_way);

      wr_entry        = '0;
      wr_entry.valid  = 1'b1;
      wr_entry.tag    = u_tag;
      wr_entry.target = bus.update_target;
`ifdef TARGET_CONF_EN
      u_old         = mem_q[u_idx][u_hit_way];
      wr_entry.conf = 2'd1;
      if (u_hit) begin
         if (u_old.target == bus.update_target) begin
            wr_entry.conf = (u_old.conf == 2'd3) ? 2'd3 : u_old.conf + 2'd1;
         end else if (u_old.conf != 2'd0) begin
            // A confident entry survives one disagreeing update.
            wr_entry.conf   = u_old.conf - 2'd1;
            wr_entry.target = u_old.target;
         end
      end
`endif
   end

   // Target/tag arrays carry no reset; the sweep only clears valid bits.
   always_ff @(posedge clk) begin
      if (clr_en) begin
         for (int w = 0; w < WAYS; w++) mem_q[cnt_q][w].valid <= 1'b0;
      end else if (u_act) begin
         mem_q[u_idx][wr_way] <= wr_entry;
      end
   end

   generate
      if (WAYS > 1) begin : g_plru
         tc_plru u_plru (
            .clk         (clk),
            .clr_en      (clr_en),
            .clr_idx     (cnt_q),
            .touch_a_en  (lk_act && l_hit),
            .touch_a_idx (l_idx),
            .touch_a_way (l_way),
            .touch_b_en  (u_act),
            .touch_b_idx (u_idx),
            .touch_b_way (wr_way),
            .vic_idx     (u_idx),
            .vic_way     (vic_way)
         );
      end else begin : g_no_plru
         assign vic_way = '0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!resetn) begin
         pred_valid_q  <= 1'b0;
         pred_hit_q    <= 1'b0;
         pred_target_q <= '0;
      end else begin
         pred_valid_q  <= pred_valid_d;
         pred_hit_q    <= pred_hit_d;
         pred_target_q <= pred_target_d;
      end
   end

   assign bus.pred_valid  = pred_valid_q;
   assign bus.pred_hit    = pred_hit_q;
   assign bus.pred_target = pred_target_q;

endmodule

// File: tb/tb_tagged_target_cache.sv
// Bench for tagged_target_cache: directed scenarios plus randomized traffic,
// checked against a true-LRU associative reference model (equivalent to tree
// PLRU for two ways).  Honours TARGET_CONF_EN like the design.
module tb_tagged_target_cache;
   import tc_pkg::*;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   tagged_target_cache_if tb_if ();

   tagged_target_cache dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (tb_if.slave)
   );

   int n_chk = 0;
   int n_err = 0;

   bit          m_valid [SETS][WAYS];
   int unsigned m_tag   [SETS][WAYS];
   logic [31:0] m_tgt   [SETS][WAYS];
   int unsigned m_conf  [SETS][WAYS];
   int unsigned m_age   [SETS][WAYS];
   int unsigned m_time;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic int unsigned m_set(input logic [31:0] pc, input logic [BHR_W-1:0] bhr);
      return ((int'(pc) >> 2) ^ (int'(pc) >> 10) ^ int'(bhr)) & 32'hFF;
   endfunction

   function automatic int unsigned m_tagf(input logic [31:0] pc, input logic [BHR_W-1:0] bhr);
      return ((pc >> 18) ^ (32'(bhr) >> 8)) & 32'hFF;
   endfunction

   task automatic model_clear();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 1'b0;
            m_age[s][w]   = 0;
         end
      m_time = 0;
   endtask

   task automatic m_touch(input int unsigned s, input int w);
      m_time++;
      m_age[s][w] = m_time;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One RUN-mode cycle: drive, predict, clock, compare.
   task automatic cycle(input bit le, input logic [31:0] lpc, input logic [BHR_W-1:0] lbhr,
                        input bit ue, input logic [31:0] upc, input logic [BHR_W-1:0] ubhr,
                        input logic [31:0] utgt, input string tag);
      int unsigned ls, lt, us, ut;
      int          lw, uw;
      bit          e_hit;
      logic [31:0] e_tgt;
      tb_if.lookup_en     = le;
      tb_if.lookup_pc     = lpc;
      tb_if.lookup_bhr    = lbhr;
      tb_if.update_en     = ue;
      tb_if.update_pc     = upc;
      tb_if.update_bhr    = ubhr;
      tb_if.update_target = utgt;

      ls = m_set(lpc, lbhr);
      lt = m_tagf(lpc, lbhr);
      lw = -1;
      if (le)
         for (int w = 0; w < WAYS; w++)
            if (m_valid[ls][w] && m_tag[ls][w] == lt) lw = w;
      e_hit = (lw >= 0);
      e_tgt = e_hit ? m_tgt[ls][lw] : 32'h0;

      us = m_set(upc, ubhr);
      ut = m_tagf(upc, ubhr);
      uw = -1;
      if (ue) begin
         for (int w = 0; w < WAYS; w++)
            if (m_valid[us][w] && m_tag[us][w] == ut) uw = w;
         if (uw >= 0) begin
`ifdef TARGET_CONF_EN
            if (m_tgt[us][uw] == utgt) begin
               if (m_conf[us][uw] < 3) m_conf[us][uw]++;
            end else if (m_conf[us][uw] > 0) begin
               m_conf[us][uw]--;
            end else begin
               m_tgt[us][uw]  = utgt;
               m_conf[us][uw] = 1;
            end
`else
            m_tgt[us][uw] = utgt;
`endif
         end else begin
            for (int w = 0; w < WAYS; w++)
               if (!m_valid[us][w] && uw < 0) uw = w;
            if (uw < 0) begin
               uw = 0;
               for (int w = 1; w < WAYS; w++)
                  if (m_age[us][w] < m_age[us][uw]) uw = w;
            end
            m_valid[us][uw] = 1'b1;
            m_tag[us][uw]   = ut;
            m_tgt[us][uw]   = utgt;
            m_conf[us][uw]  = 1;
         end
      end
      // Lookup touch first so the update's touch ends up most recent.
      if (e_hit) m_touch(ls, lw);
      if (ue) m_touch(us, uw);

      tick();
      check_val({tag, ".valid"},  32'(tb_if.pred_valid), 32'(le));
      check_val({tag, ".hit"},    32'(tb_if.pred_hit),   32'(e_hit));
      check_val({tag, ".target"}, tb_if.pred_target,     e_tgt);
      tb_if.lookup_en = 1'b0;
      tb_if.update_en = 1'b0;
   endtask

   // Counts the 256-cycle init sweep after resetn has just been released.
   task automatic sweep(input string tag, input bit probe);
      for (int k = 1; k <= SETS; k++) begin
         if (probe && k == 10) begin
            tb_if.lookup_en  = 1'b1;
            tb_if.lookup_pc  = 32'h0040_1230;
            tb_if.lookup_bhr = 10'h155;
         end
         if (probe && k == 20) begin
            tb_if.update_en     = 1'b1;
            tb_if.update_pc     = 32'h0020_0000;
            tb_if.update_bhr    = 10'h000;
            tb_if.update_target = 32'hDEAD_0000;
         end
         tick();
         tb_if.lookup_en = 1'b0;
         tb_if.update_en = 1'b0;
         if (probe && k == 10) check_val({tag, ".init_lookup_valid"}, 32'(tb_if.pred_valid), 32'h0);
         if (k == 1)    check_val({tag, ".ready_c1"},   32'(tb_if.ready), 32'h0);
         if (k == 255)  check_val({tag, ".ready_c256"}, 32'(tb_if.ready), 32'h0);
         if (k == SETS) check_val({tag, ".ready_c257"}, 32'(tb_if.ready), 32'h1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
      $fatal(1);
   end

   initial begin
      logic [31:0] tpool [4];
      logic [31:0] pa, pb, pc, pe, pf, lpc, upc;
      logic [BHR_W-1:0] lbhr, ubhr;
      bit le, ue;

      tb_if.lookup_en = 1'b0;  tb_if.lookup_pc = '0;  tb_if.lookup_bhr = '0;
      tb_if.update_en = 1'b0;  tb_if.update_pc = '0;  tb_if.update_bhr = '0;
      tb_if.update_target = '0;

      resetn = 1'b0;
      repeat (3) tick();
      check_val("rst.ready",       32'(tb_if.ready),      32'h0);
      check_val("rst.pred_valid",  32'(tb_if.pred_valid), 32'h0);
      check_val("rst.pred_hit",    32'(tb_if.pred_hit),   32'h0);
      check_val("rst.pred_target", tb_if.pred_target,     32'h0);
      resetn = 1'b1;
      sweep("init", 1'b1);
      model_clear();

      cycle(0, 0, 0, 1, 32'h0040_1230, 10'h155, 32'h0040_8000, "d1.upd");
      cycle(1, 32'h0040_1230, 10'h155, 0, 0, 0, 0, "d1.look");
      check_val("d1.hit_const",    32'(tb_if.pred_hit), 32'h1);
      check_val("d1.target_const", tb_if.pred_target,   32'h0040_8000);
      cycle(1, 32'h0040_1230, 10'h000, 0, 0, 0, 0, "d1.bhr0");
      check_val("d1.bhr0_hit_const", 32'(tb_if.pred_hit), 32'h0);
      cycle(1, 32'h0020_0000, 10'h000, 0, 0, 0, 0, "d1.init_upd_dropped");
      check_val("d1.dropped_hit_const", 32'(tb_if.pred_hit), 32'h0);

      pa = 32'h0010_0040; pb = 32'h0014_0040; pc = 32'h0018_0040;
      cycle(0, 0, 0, 1, pa, 0, 32'hAAAA_0000, "ev.upd_a");
      cycle(0, 0, 0, 1, pb, 0, 32'hBBBB_0000, "ev.upd_b");
      cycle(1, pa, 0, 0, 0, 0, 0, "ev.look_a");
      cycle(0, 0, 0, 1, pc, 0, 32'hCCCC_0000, "ev.upd_c");
      cycle(1, pa, 0, 0, 0, 0, 0, "ev.look_a2");
      check_val("ev.a_hit_const", 32'(tb_if.pred_hit), 32'h1);
      cycle(1, pc, 0, 0, 0, 0, 0, "ev.look_c");
      check_val("ev.c_target_const", tb_if.pred_target, 32'hCCCC_0000);
      cycle(1, pb, 0, 0, 0, 0, 0, "ev.look_b");
      check_val("ev.b_hit_const", 32'(tb_if.pred_hit), 32'h0);

      pe = 32'h0010_0080;
      cycle(1, pe, 0, 1, pe, 0, 32'hEEEE_0000, "rw.same");
      check_val("rw.same_hit_const", 32'(tb_if.pred_hit), 32'h0);
      cycle(1, pe, 0, 0, 0, 0, 0, "rw.next");
      check_val("rw.next_target_const", tb_if.pred_target, 32'hEEEE_0000);

      pf = 32'h0010_00C0;
      cycle(0, 0, 0, 1, pf, 0, 32'h1111_0000, "cf.t1");
      cycle(0, 0, 0, 1, pf, 0, 32'h2222_0000, "cf.t2a");
      cycle(1, pf, 0, 0, 0, 0, 0, "cf.look1");
`ifdef TARGET_CONF_EN
      check_val("cf.look1_const", tb_if.pred_target, 32'h1111_0000);
`else
      check_val("cf.look1_const", tb_if.pred_target, 32'h2222_0000);
`endif
      cycle(0, 0, 0, 1, pf, 0, 32'h2222_0000, "cf.t2b");
      cycle(1, pf, 0, 0, 0, 0, 0, "cf.look2");
      check_val("cf.look2_const", tb_if.pred_target, 32'h2222_0000);

      for (int i = 0; i < 4; i++) tpool[i] = $urandom;
      for (int i = 0; i < 3000; i++) begin
         le   = ($urandom_range(0, 3) != 0);
         ue   = ($urandom_range(0, 1) != 0);
         lpc  = 32'h0040_0000 | (32'($urandom_range(0, 7)) << 18) | (32'($urandom_range(0, 3)) << 2);
         lbhr = BHR_W'($urandom_range(0, 1023) & 32'h303);
         if ($urandom_range(0, 3) == 0) begin
            upc  = lpc;
            ubhr = lbhr;
         end else begin
            upc  = 32'h0040_0000 | (32'($urandom_range(0, 7)) << 18) | (32'($urandom_range(0, 3)) << 2);
            ubhr = BHR_W'($urandom_range(0, 1023) & 32'h303);
         end
         cycle(le, lpc, lbhr, ue, upc, ubhr, tpool[$urandom_range(0, 3)], "rnd");
      end

      for (int i = 0; i < 5; i++)
         cycle(0, 0, 0, 1, 32'h0030_0000 + 32'(i * 4), 0, 32'h5000_0000 + 32'(i), "mr.upd");
      cycle(1, 32'h0030_0008, 0, 0, 0, 0, 0, "mr.pre_look");
      resetn = 1'b0;
      tick();
      check_val("mr.ready_drop", 32'(tb_if.ready), 32'h0);
      resetn = 1'b1;
      sweep("mr", 1'b0);
      model_clear();
      for (int i = 0; i < 5; i++) begin
         cycle(1, 32'h0030_0000 + 32'(i * 4), 0, 0, 0, 0, 0, "mr.look");
         check_val("mr.hit_const", 32'(tb_if.pred_hit), 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
